// File: rtl/plab5_mcore_dma_arbiter.sv
// Round-robin arbiter that serializes N core DMA requesters onto one checker path.
// Optional: PLAB5_MCORE_DMA_ARB_DOMAIN_PRIO_EN gives domain-1 requesters priority in IDLE.
module plab5_mcore_dma_arbiter #(
  parameter int p_num_cores   = 4,
  parameter int p_addr_nbits  = 32,
  parameter int p_ctrl_nbits  = 47,
  parameter int p_rctrl_nbits = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_num_cores-1:0]                req_val,
  output logic [p_num_cores-1:0]                req_rdy,
  input  logic [p_num_cores-1:0]                req_domain,
  input  logic [p_num_cores*p_addr_nbits-1:0]   req_src_addr,
  input  logic [p_num_cores*p_addr_nbits-1:0]   req_dest_addr,
  input  logic [p_num_cores*p_ctrl_nbits-1:0]   req_control,
  output logic [p_num_cores-1:0]                resp_val,
  output logic                                  resp_domain,
  output logic [p_rctrl_nbits-1:0]              resp_control,
  output logic                                  chk_val,
  input  logic                                  chk_rdy,
  output logic                                  chk_domain,
  output logic [p_addr_nbits-1:0]               chk_src_addr,
  output logic [p_addr_nbits-1:0]               chk_dest_addr,
  output logic [p_ctrl_nbits-1:0]               chk_req_control,
  input  logic                                  chk_ack,
  input  logic                                  chk_resp_domain,
  input  logic [p_rctrl_nbits-1:0]              chk_resp_control
);
  localparam int PW = $clog2(p_num_cores);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]            rr_ptr, grant_idx, win_idx;
  logic                     win_found;
  logic [PW:0]              idx;
  logic [p_num_cores-1:0]   cand;
  logic                     dom_r, resp_dom_r;
  logic [p_addr_nbits-1:0]  src_r, dest_r;
  logic [p_ctrl_nbits-1:0]  ctrl_r;
  logic [p_rctrl_nbits-1:0] resp_ctrl_r;

  always_comb begin
`ifdef PLAB5_MCORE_DMA_ARB_DOMAIN_PRIO_EN
    cand = (|(req_val & req_domain)) ? (req_val & req_domain) : req_val;
`else
    cand = req_val;
`endif
  end

  // Scan candidates starting at rr_ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < p_num_cores; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(p_num_cores)) idx = idx - (PW+1)'(p_num_cores);
      if (!win_found && cand[idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE:   if (chk_rdy)   state_nxt = WAIT;
      WAIT:    if (chk_ack)   state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      dom_r       <= 1'b0;
      src_r       <= '0;
      dest_r      <= '0;
      ctrl_r      <= '0;
      resp_dom_r  <= 1'b0;
      resp_ctrl_r <= '0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          grant_idx <= win_idx;
          dom_r     <= req_domain[win_idx];
          src_r     <= req_src_addr[int'(win_idx)*p_addr_nbits +: p_addr_nbits];
          dest_r    <= req_dest_addr[int'(win_idx)*p_addr_nbits +: p_addr_nbits];
          ctrl_r    <= req_control[int'(win_idx)*p_ctrl_nbits +: p_ctrl_nbits];
        end
        WAIT: if (chk_ack) begin
          resp_dom_r  <= chk_resp_domain;
          resp_ctrl_r <= chk_resp_control;
        end
        RESP: rr_ptr <= (grant_idx == PW'(p_num_cores-1)) ? '0 : grant_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Payload outputs are gated so they read zero whenever the matching valid is low.
  always_comb begin
    req_rdy = '0;
    if (state == IDLE && win_found) req_rdy[win_idx] = 1'b1;
    resp_val = '0;
    if (state == RESP) resp_val[grant_idx] = 1'b1;
  end

  assign resp_domain     = (state == RESP) & resp_dom_r;
  assign resp_control    = (state == RESP) ? resp_ctrl_r : '0;
  assign chk_val         = (state == ISSUE);
  assign chk_domain      = chk_val & dom_r;
  assign chk_src_addr    = chk_val ? src_r  : '0;
  assign chk_dest_addr   = chk_val ? dest_r : '0;
  assign chk_req_control = chk_val ? ctrl_r : '0;
endmodule
